// File: rtl/data_modulate_3x3_window_if.sv
// Pixel-stream and 3x3 window bundle between a raster source and the window generator.
// The master drives the pixel stream, and the slave (the generator) returns the windows.
interface data_modulate_3x3_window_if #(
    parameter int DATA_WIDTH = 8
);
    logic                    start_i;
    logic                    valid_i;
    logic [DATA_WIDTH-1:0]   data_i;
    logic [9*DATA_WIDTH-1:0] window_o;
    logic                    valid_o;
    logic [2:0]              row_cnt_o;
    logic                    done_o;

    modport master (
        output start_i, valid_i, data_i,
        input  window_o, valid_o, row_cnt_o, done_o
    );

    modport slave (
        input  start_i, valid_i, data_i,
        output window_o, valid_o, row_cnt_o, done_o
    );
endinterface

// File: rtl/data_modulate_3x3_window.sv
// Builds a sliding 3x3 window from a raster pixel stream using two line buffers.
// A window is emitted one cycle after its bottom-right pixel is accepted.
module data_modulate_3x3_window #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input logic                       clk,
    input logic                       rst,
    data_modulate_3x3_window_if.slave bus
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [1:0]                  state_q, state_d;
    logic [CW-1:0]               col_q, col_d;
    logic [RW-1:0]               row_q, row_d;
    logic [2:0]                  row_cnt_q, row_cnt_d;
    logic [8:0][DATA_WIDTH-1:0]  win_q, win_d;
    logic                        valid_q, valid_d;

    logic [DATA_WIDTH-1:0]       lb1_q [IMG_WIDTH];
    logic [DATA_WIDTH-1:0]       lb2_q [IMG_WIDTH];
    logic [DATA_WIDTH-1:0]       lb1_rd, lb2_rd;

    logic accept, col_last, row_last;

    assign accept   = bus.valid_i && ((state_q == ST_FILL) || (state_q == ST_RUN));
    assign col_last = (col_q == COL_LAST);
    assign row_last = (row_q == ROW_LAST);
    assign lb1_rd   = lb1_q[col_q];
    assign lb2_rd   = lb2_q[col_q];

    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned and infers a latch.
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        row_cnt_d = row_cnt_q;
        win_d     = win_q;
        valid_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_d   = ST_FILL;
                    col_d     = '0;
                    row_d     = '0;
                    row_cnt_d = '0;
                end
            end
            ST_FILL: if (accept && col_last && (row_q == RW'(1))) state_d = ST_RUN;
            ST_RUN:  if (accept && col_last && row_last)          state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[3*r]   = win_q[3*r+1];
                win_d[3*r+1] = win_q[3*r+2];
            end
            win_d[2] = lb2_rd;
            win_d[5] = lb1_rd;
            win_d[8] = bus.data_i;

            // Windows touching rows/columns 0-1 would contain stale line-buffer data.
            valid_d = (row_q >= RW'(2)) && (col_q >= CW'(2));

            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
                if (row_cnt_q != 3'd2) row_cnt_d = row_cnt_q + 3'd1;
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            col_q     <= '0;
            row_q     <= '0;
            row_cnt_q <= '0;
            win_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            row_cnt_q <= row_cnt_d;
            win_q     <= win_d;
            valid_q   <= valid_d;
        end
    end

    // NOTE: line buffers have no reset so they map to RAM; the valid gating hides their stale contents.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2_q[col_q] <= lb1_q[col_q];
            lb1_q[col_q] <= bus.data_i;
        end
    end

    assign bus.window_o  = win_q;
    assign bus.valid_o   = valid_q;
    assign bus.row_cnt_o = row_cnt_q;
    assign bus.done_o    = (state_q == ST_DONE);
endmodule

// File: doc/data_modulate_3x3_window.md
DATA_MODULATE_3X3_WINDOW -- requirements
Module: data_modulate_3x3_window

Interface
REQ-001 Parameter DATA_WIDTH, default 8: pixel width in bits.
REQ-002 Parameter IMG_WIDTH, default 640: pixels per row, >= 3.
REQ-003 Parameter IMG_HEIGHT, default 480: rows per frame, >= 3.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start_i  input  1  one-cycle frame start strobe.
REQ-007 valid_i  input  1  data_i carries a pixel this cycle; no backpressure.
REQ-008 data_i  input  DATA_WIDTH  raster-order pixel.
REQ-009 window_o  output  9*DATA_WIDTH  3x3 window; element k = 3*r+c at window_o[k*DATA_WIDTH +: DATA_WIDTH], r=0 oldest row, c=0 oldest column.
REQ-010 valid_o  output  1  window_o holds a complete valid window this cycle.
REQ-011 row_cnt_o  output  3  completed rows in frame, saturating at 2 (consumer's i_counter).
REQ-012 done_o  output  1  one-cycle end-of-frame pulse (consumer's done_i).

Function
REQ-013 FSM states IDLE, FILL, RUN, DONE; SHALL reset to IDLE.
REQ-014 IDLE: start_i=1 -> FILL; column, row, row_cnt_o counters cleared to 0; valid_i ignored in IDLE.
REQ-015 FILL -> RUN when the last pixel (col IMG_WIDTH-1) of row 1 is accepted.
REQ-016 RUN -> DONE when pixel (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted; DONE -> IDLE unconditionally next cycle.
REQ-017 start_i outside IDLE SHALL be ignored.
REQ-018 Accepted pixel = valid_i=1 in FILL or RUN; column counter 0..IMG_WIDTH-1 wraps to 0 and increments row counter at row end.
REQ-019 Two line buffers LB1, LB2, depth IMG_WIDTH, addressed by column counter; on accept at column c: read LB1[c], LB2[c]; write LB2[c]<=LB1[c], LB1[c]<=data_i (read-before-write same cycle).
REQ-020 On accept the window shifts one column: c0<=c1, c1<=c2 per row; new column c2 = {r0: LB2[c], r1: LB1[c], r2: data_i}.
REQ-021 valid_o SHALL be 1 exactly the cycle after an accept with row >= 2 and col >= 2; otherwise 0 (no padding; (IMG_HEIGHT-2)*(IMG_WIDTH-2) windows/frame).
REQ-022 Latency: window whose bottom-right pixel is accepted in cycle t appears on window_o in cycle t+1.
REQ-023 valid_i gaps: window_o holds value, valid_o=0, counters hold.
REQ-024 row_cnt_o increments at each row end, saturates at 2, clears on start_i in IDLE.
REQ-025 done_o=1 for exactly the DONE cycle, i.e. same cycle as the final valid_o.
REQ-026 Line buffer contents need not be cleared; gating in REQ-021 masks stale data.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, counters 0, window registers 0, valid_o=0, done_o=0, row_cnt_o=0, regardless of clock.
REQ-028 Reset mid-frame abandons the frame; next frame requires a new start_i.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, pixel value = 4*row+col)
REQ-029 start_i, 16 pixels back-to-back -> first valid_o one cycle after pixel 10 accepted, window_o = {0,1,2,4,5,6,8,9,10}; exactly 4 valid_o pulses; last window {5,6,7,9,10,11,13,14,15}.
REQ-030 Same frame -> row_cnt_o 0,1,2 after pixels 3 and 7, stays 2; done_o single pulse coinciding with final valid_o, then IDLE.
REQ-031 Same frame with valid_i low every other cycle -> identical window sequence, valid_o never high in a gap cycle.
REQ-032 valid_i pixels without start_i -> no valid_o, no done_o, counters stay 0.
REQ-033 start_i re-asserted after pixel 5 -> ignored; frame completes normally.
REQ-034 rst asserted after pixel 9, released, new start_i + full frame -> all outputs 0 during reset; second frame matches REQ-029.
